// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop input synchroniser, mid-bit sampling, optional parity,
// one or two stop bits; each frame is reported with a one-cycle valid strobe and error flags.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW   = $clog2(DATA_BITS);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;
  state_e state_q, state_d;

  logic                 rxd_meta_q, rxd_s_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [BW-1:0]        bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic                 par_err_q, frm_err_q;
  logic                 valid_q, perr_q, ferr_q;
  logic                 sample, last_data, last_stop, frame_done, exp_par;

  // Start bit is sampled half a bit in; every later bit one full bit after the previous sample.
  always_comb begin
    sample = 1'b0;
    case (state_q)
      StStart:                sample = (clk_cnt_q == CW'(HALF - 1));
      StData, StPar, StStop:  sample = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
      default:                sample = 1'b0;
    endcase
  end

  assign last_data  = (bit_cnt_q == BW'(DATA_BITS - 1));
  assign last_stop  = (stop_cnt_q == 1'(STOP_BITS - 1));
  assign frame_done = (state_q == StStop) && sample && last_stop;
  assign exp_par    = (PARITY == 1) ? ~^shift_q : ^shift_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rxd_s_q) state_d = StStart;
      StStart: if (sample) state_d = rxd_s_q ? StIdle : StData;
      StData:  if (sample && last_data) state_d = (PARITY != 0) ? StPar : StStop;
      StPar:   if (sample) state_d = StStop;
      StStop:  if (sample && last_stop) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Busy covers the strobe cycle too, even though the FSM is already back in idle.
  always_comb begin
    o_busy       = (state_q != StIdle) || valid_q;
    o_valid      = valid_q;
    o_data       = data_q;
    o_parity_err = perr_q && (PARITY != 0);
    o_frame_err  = ferr_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= i_rxd;
      rxd_s_q    <= rxd_meta_q;
      clk_cnt_q  <= (state_q == StIdle || sample) ? '0 : clk_cnt_q + 1'b1;

      if (state_q == StStart) begin
        bit_cnt_q <= '0;
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end
      if (state_q != StStop) stop_cnt_q <= 1'b0;

      if (sample) begin
        case (state_q)
          StData: begin
            shift_q   <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
          StPar:   par_err_q <= exp_par ^ rxd_s_q;
          StStop: begin
            stop_cnt_q <= stop_cnt_q + 1'b1;
            if (!rxd_s_q) frm_err_q <= 1'b1;
          end
          default: ;
        endcase
      end

      valid_q <= frame_done;
      if (frame_done) begin
        data_q <= shift_q;
        perr_q <= par_err_q;
        ferr_q <= frm_err_q | ~rxd_s_q;
      end
    end
  end
endmodule
